// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the pierogi multi-cycle controller.
package ctrl_pkg;

  localparam int unsigned OP_W     = 4;
  localparam int unsigned STATE_W  = 3;
  localparam int unsigned PC_SRC_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5,
    ST_FAULT  = 3'd6
  } state_t;

  localparam logic [OP_W-1:0] OP_AND  = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR   = 4'b0001;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b0010;
  localparam logic [OP_W-1:0] OP_NOR  = 4'b0011;
  localparam logic [OP_W-1:0] OP_ADD  = 4'b0100;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0101;
  localparam logic [OP_W-1:0] OP_SLT  = 4'b0110;
  localparam logic [OP_W-1:0] OP_J    = 4'b0111;
  localparam logic [OP_W-1:0] OP_BEQ  = 4'b1000;
  localparam logic [OP_W-1:0] OP_BNE  = 4'b1001;
  localparam logic [OP_W-1:0] OP_ANDI = 4'b1010;
  localparam logic [OP_W-1:0] OP_ORI  = 4'b1011;
  localparam logic [OP_W-1:0] OP_ADDI = 4'b1100;
  localparam logic [OP_W-1:0] OP_CMP  = 4'b1101;
  localparam logic [OP_W-1:0] OP_LW   = 4'b1110;
  localparam logic [OP_W-1:0] OP_SW   = 4'b1111;

  localparam logic [PC_SRC_W-1:0] PC_SRC_INC    = 2'd0;
  localparam logic [PC_SRC_W-1:0] PC_SRC_JUMP   = 2'd1;
  localparam logic [PC_SRC_W-1:0] PC_SRC_BRANCH = 2'd2;

  localparam logic [OP_W-1:0] ALU_ADD = 4'b0100;

  // Single-bit control strobes; alu_op is carried separately since its width is a parameter.
  typedef struct packed {
    logic                mem_req;
    logic                mem_we;
    logic                addr_sel;
    logic                ir_we;
    logic                pc_we;
    logic [PC_SRC_W-1:0] pc_src;
    logic                alu_b_sel;
    logic                reg_we;
    logic                wb_sel;
    logic                halted;
    logic                fault;
  } ctrl_out_t;

  function automatic logic branch_taken(input logic [OP_W-1:0] op, input logic eq);
    logic taken;
    taken = 1'b0;
    if (op == OP_J)   taken = 1'b1;
    if (op == OP_BEQ) taken = eq;
    if (op == OP_BNE) taken = ~eq;
    return taken;
  endfunction

  function automatic logic [PC_SRC_W-1:0] branch_src(input logic [OP_W-1:0] op);
    return (op == OP_J) ? PC_SRC_JUMP : PC_SRC_BRANCH;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode into ALU controls and instruction class flags.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned ALU_W = 4
) (
  input  logic [OP_W-1:0]  i_opcode,
  output logic [ALU_W-1:0] o_alu_op,
  output logic             o_alu_b_sel,
  output logic             o_wb_sel,
  output logic             o_is_alu,
  output logic             o_is_mem,
  output logic             o_is_store,
  output logic             o_is_branch
);

  always_comb begin
    o_alu_op    = ALU_W'(i_opcode);
    o_alu_b_sel = 1'b0;
    o_wb_sel    = 1'b0;
    o_is_alu    = 1'b0;
    o_is_mem    = 1'b0;
    o_is_store  = 1'b0;
    o_is_branch = 1'b0;
    case (i_opcode)
      OP_AND, OP_OR, OP_XOR, OP_NOR, OP_ADD, OP_SUB, OP_SLT: o_is_alu = 1'b1;
      OP_J, OP_BEQ, OP_BNE: o_is_branch = 1'b1;
      OP_ANDI, OP_ORI, OP_CMP: begin
        o_is_alu    = 1'b1;
        o_alu_b_sel = 1'b1;
      end
      OP_ADDI: begin
        o_is_alu    = 1'b1;
        o_alu_b_sel = 1'b1;
        o_alu_op    = ALU_W'(ALU_ADD);
      end
      OP_LW: begin
        o_is_mem = 1'b1;
        o_wb_sel = 1'b1;
      end
      OP_SW: begin
        o_is_mem   = 1'b1;
        o_is_store = 1'b1;
      end
      default: o_is_alu = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory watchdog and halt.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int unsigned ALU_W       = 4,
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned FAST_BRANCH = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OP_W-1:0]     opcode,
  input  logic                Eq,
  input  logic                mem_ready,
  input  logic                halt_req,
  output logic                mem_req,
  output logic                mem_we,
  output logic                addr_sel,
  output logic                ir_we,
  output logic                pc_we,
  output logic [PC_SRC_W-1:0] pc_src,
  output logic                alu_b_sel,
  output logic [ALU_W-1:0]    alu_op,
  output logic                reg_we,
  output logic                wb_sel,
  output logic [STATE_W-1:0]  state,
  output logic                halted,
  output logic                fault
);

  localparam int unsigned       CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  state_t           w_fetch_or_halt;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             w_waiting;
  logic             w_timeout;
  logic             w_fast;
  ctrl_out_t        w_out;
  ctrl_out_t        w_out_g;
  logic [ALU_W-1:0] w_alu_op;

  logic [ALU_W-1:0] w_dec_alu_op;
  logic             w_dec_alu_b_sel;
  logic             w_dec_wb_sel;
  logic             w_dec_is_alu;
  logic             w_dec_is_mem;
  logic             w_dec_is_store;
  logic             w_dec_is_branch;

  ctrl_decode #(.ALU_W(ALU_W)) u_decode (
    .i_opcode    (opcode),
    .o_alu_op    (w_dec_alu_op),
    .o_alu_b_sel (w_dec_alu_b_sel),
    .o_wb_sel    (w_dec_wb_sel),
    .o_is_alu    (w_dec_is_alu),
    .o_is_mem    (w_dec_is_mem),
    .o_is_store  (w_dec_is_store),
    .o_is_branch (w_dec_is_branch)
  );

  // A wait cycle that would be the TIMEOUT-th one without mem_ready trips the watchdog.
  assign w_waiting       = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !mem_ready;
  assign w_timeout       = w_waiting && (r_wait_cnt == WAIT_LAST);
  assign w_fetch_or_halt = halt_req ? ST_HALT : ST_FETCH;
  assign w_fast          = (FAST_BRANCH != 0) && w_dec_is_branch;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_FETCH;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_wait_cnt <= '0;
      end else if (w_waiting) begin
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    w_out    = '0;
    w_alu_op = '0;
    case (r_state)
      ST_FETCH: begin
        w_out.mem_req = 1'b1;
        if (w_timeout) begin
          w_next = ST_FAULT;
        end else if (mem_ready) begin
          w_out.ir_we  = 1'b1;
          w_out.pc_we  = 1'b1;
          w_out.pc_src = PC_SRC_INC;
          w_next       = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (w_fast) begin
          w_out.pc_we  = branch_taken(opcode, Eq);
          w_out.pc_src = branch_src(opcode);
          w_next       = w_fetch_or_halt;
        end else begin
          w_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_alu_op        = w_dec_alu_op;
        w_out.alu_b_sel = w_dec_alu_b_sel;
        if (w_dec_is_mem) begin
          w_next = ST_MEM;
        end else if (w_dec_is_branch) begin
          w_out.pc_we  = branch_taken(opcode, Eq);
          w_out.pc_src = branch_src(opcode);
          w_next       = w_fetch_or_halt;
        end else if (w_dec_is_alu) begin
          w_next = ST_WB;
        end else begin
          w_next = w_fetch_or_halt;
        end
      end
      ST_MEM: begin
        w_out.mem_req   = 1'b1;
        w_out.mem_we    = w_dec_is_store;
        w_out.addr_sel  = 1'b1;
        w_out.alu_b_sel = 1'b1;
        w_alu_op        = ALU_W'(ALU_ADD);
        if (w_timeout) begin
          w_next = ST_FAULT;
        end else if (mem_ready) begin
          w_next = w_dec_is_store ? w_fetch_or_halt : ST_WB;
        end
      end
      ST_WB: begin
        w_out.reg_we = 1'b1;
        w_out.wb_sel = w_dec_wb_sel;
        w_next       = w_fetch_or_halt;
      end
      ST_HALT: begin
        w_out.halted = 1'b1;
        if (!halt_req) w_next = ST_FETCH;
      end
      ST_FAULT: w_out.fault = 1'b1;
      default:  w_next = ST_FAULT;
    endcase
  end

  // Reset masks every output, including the visible state encoding.
  assign w_out_g   = reset ? '0 : w_out;
  assign mem_req   = w_out_g.mem_req;
  assign mem_we    = w_out_g.mem_we;
  assign addr_sel  = w_out_g.addr_sel;
  assign ir_we     = w_out_g.ir_we;
  assign pc_we     = w_out_g.pc_we;
  assign pc_src    = w_out_g.pc_src;
  assign alu_b_sel = w_out_g.alu_b_sel;
  assign reg_we    = w_out_g.reg_we;
  assign wb_sel    = w_out_g.wb_sel;
  assign halted    = w_out_g.halted;
  assign fault     = w_out_g.fault;
  assign alu_op    = reset ? '0 : w_alu_op;
  assign state     = reset ? '0 : STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed vector bench for multicycle_control (normal and fast-branch builds).
module tb_multicycle_control;

  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

  logic       clk;
  logic       rst;
  logic [3:0] op;
  logic       eq;
  logic       mr;
  logic       hr;

  logic       n_mem_req, n_mem_we, n_addr_sel, n_ir_we, n_pc_we, n_alu_b_sel, n_reg_we, n_wb_sel, n_halted, n_fault;
  logic [1:0] n_pc_src;
  logic [3:0] n_alu_op;
  logic [2:0] n_state;
  logic       f_mem_req, f_mem_we, f_addr_sel, f_ir_we, f_pc_we, f_alu_b_sel, f_reg_we, f_wb_sel, f_halted, f_fault;
  logic [1:0] f_pc_src;
  logic [3:0] f_alu_op;
  logic [2:0] f_state;

  multicycle_control #(.ALU_W(4), .TIMEOUT(4), .FAST_BRANCH(0)) u_dut (
    .clk(clk), .reset(rst), .opcode(op), .Eq(eq), .mem_ready(mr), .halt_req(hr),
    .mem_req(n_mem_req), .mem_we(n_mem_we), .addr_sel(n_addr_sel), .ir_we(n_ir_we),
    .pc_we(n_pc_we), .pc_src(n_pc_src), .alu_b_sel(n_alu_b_sel), .alu_op(n_alu_op),
    .reg_we(n_reg_we), .wb_sel(n_wb_sel), .state(n_state), .halted(n_halted), .fault(n_fault)
  );

  multicycle_control #(.ALU_W(4), .TIMEOUT(4), .FAST_BRANCH(1)) u_dut_fb (
    .clk(clk), .reset(rst), .opcode(op), .Eq(eq), .mem_ready(mr), .halt_req(hr),
    .mem_req(f_mem_req), .mem_we(f_mem_we), .addr_sel(f_addr_sel), .ir_we(f_ir_we),
    .pc_we(f_pc_we), .pc_src(f_pc_src), .alu_b_sel(f_alu_b_sel), .alu_op(f_alu_op),
    .reg_we(f_reg_we), .wb_sel(f_wb_sel), .state(f_state), .halted(f_halted), .fault(f_fault)
  );

  logic [18:0] got_n, got_f;
  assign got_n = {n_state, n_mem_req, n_mem_we, n_addr_sel, n_ir_we, n_pc_we, n_pc_src,
                  n_alu_b_sel, n_alu_op, n_reg_we, n_wb_sel, n_halted, n_fault};
  assign got_f = {f_state, f_mem_req, f_mem_we, f_addr_sel, f_ir_we, f_pc_we, f_pc_src,
                  f_alu_b_sel, f_alu_op, f_reg_we, f_wb_sel, f_halted, f_fault};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  op;
    logic        eq;
    logic        mr;
    logic        hr;
    logic        fb;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks;
  int   n_fail;

  function automatic logic [18:0] ex(input logic [2:0] st, input logic mreq, input logic mwe,
                                     input logic asel, input logic irwe, input logic pcwe,
                                     input logic [1:0] pcsrc, input logic bsel, input logic [3:0] aop,
                                     input logic rwe, input logic wsel, input logic hlt, input logic flt);
    return {st, mreq, mwe, asel, irwe, pcwe, pcsrc, bsel, aop, rwe, wsel, hlt, flt};
  endfunction

  function automatic logic [18:0] e_zero();
    return ex(3'd0, L, L, L, L, L, 2'd0, L, 4'h0, L, L, L, L);
  endfunction
  function automatic logic [18:0] e_fwait();
    return ex(3'd0, H, L, L, L, L, 2'd0, L, 4'h0, L, L, L, L);
  endfunction
  function automatic logic [18:0] e_fgo();
    return ex(3'd0, H, L, L, H, H, 2'd0, L, 4'h0, L, L, L, L);
  endfunction
  function automatic logic [18:0] e_dec(input logic pcwe, input logic [1:0] pcsrc);
    return ex(3'd1, L, L, L, L, pcwe, pcsrc, L, 4'h0, L, L, L, L);
  endfunction
  function automatic logic [18:0] e_exec(input logic [3:0] aop, input logic bsel, input logic pcwe,
                                         input logic [1:0] pcsrc);
    return ex(3'd2, L, L, L, L, pcwe, pcsrc, bsel, aop, L, L, L, L);
  endfunction
  function automatic logic [18:0] e_mem(input logic we);
    return ex(3'd3, H, we, H, L, L, 2'd0, H, 4'b0100, L, L, L, L);
  endfunction
  function automatic logic [18:0] e_wb(input logic wsel);
    return ex(3'd4, L, L, L, L, L, 2'd0, L, 4'h0, H, wsel, L, L);
  endfunction
  function automatic logic [18:0] e_halt();
    return ex(3'd5, L, L, L, L, L, 2'd0, L, 4'h0, L, L, H, L);
  endfunction
  function automatic logic [18:0] e_fault();
    return ex(3'd6, L, L, L, L, L, 2'd0, L, 4'h0, L, L, L, H);
  endfunction

  task automatic push(input logic r, input logic [3:0] o, input logic e, input logic m,
                      input logic h, input logic fb, input logic [18:0] x);
    vec_t t;
    t.rst = r; t.op = o; t.eq = e; t.mr = m; t.hr = h; t.fb = fb; t.exp = x;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic r, input logic [3:0] o, input logic e, input logic m, input logic h);
    @(negedge clk);
    rst = r; op = o; eq = e; mr = m; hr = h;
    #1;
  endtask

  task automatic chk(input string name, input int id, input logic [18:0] got, input logic [18:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s #%0d: got %05h (state %0d) required %05h (state %0d)",
               name, id, got, got[18:16], exp, exp[18:16]);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = H; op = 4'h0; eq = L; mr = L; hr = L;

    // add, memory always ready
    push(H, 4'h4, L, H, L, L, e_zero());
    push(L, 4'h4, L, H, L, L, e_fgo());
    push(L, 4'h4, L, H, L, L, e_dec(L, 2'd0));
    push(L, 4'h4, L, H, L, L, e_exec(4'h4, L, L, 2'd0));
    push(L, 4'h4, L, H, L, L, e_wb(L));
    push(L, 4'h4, L, L, L, L, e_fwait());
    // lw with two MEM wait cycles
    push(H, 4'hE, L, L, L, L, e_zero());
    push(L, 4'hE, L, H, L, L, e_fgo());
    push(L, 4'hE, L, L, L, L, e_dec(L, 2'd0));
    push(L, 4'hE, L, L, L, L, e_exec(4'hE, L, L, 2'd0));
    push(L, 4'hE, L, L, L, L, e_mem(L));
    push(L, 4'hE, L, L, L, L, e_mem(L));
    push(L, 4'hE, L, H, L, L, e_mem(L));
    push(L, 4'hE, L, L, L, L, e_wb(H));
    push(L, 4'hE, L, L, L, L, e_fwait());
    // beq taken / not taken, bne taken, j
    push(H, 4'h8, H, H, L, L, e_zero());
    push(L, 4'h8, H, H, L, L, e_fgo());
    push(L, 4'h8, H, H, L, L, e_dec(L, 2'd0));
    push(L, 4'h8, H, H, L, L, e_exec(4'h8, L, H, 2'd2));
    push(L, 4'h8, L, L, L, L, e_fwait());
    push(H, 4'h8, L, H, L, L, e_zero());
    push(L, 4'h8, L, H, L, L, e_fgo());
    push(L, 4'h8, L, H, L, L, e_dec(L, 2'd0));
    push(L, 4'h8, L, H, L, L, e_exec(4'h8, L, L, 2'd2));
    push(L, 4'h8, L, L, L, L, e_fwait());
    push(H, 4'h9, L, H, L, L, e_zero());
    push(L, 4'h9, L, H, L, L, e_fgo());
    push(L, 4'h9, L, H, L, L, e_dec(L, 2'd0));
    push(L, 4'h9, L, H, L, L, e_exec(4'h9, L, H, 2'd2));
    push(H, 4'h7, L, H, L, L, e_zero());
    push(L, 4'h7, L, H, L, L, e_fgo());
    push(L, 4'h7, L, H, L, L, e_dec(L, 2'd0));
    push(L, 4'h7, L, H, L, L, e_exec(4'h7, L, H, 2'd1));
    // addi maps to ALU add with immediate
    push(H, 4'hC, L, H, L, L, e_zero());
    push(L, 4'hC, L, H, L, L, e_fgo());
    push(L, 4'hC, L, H, L, L, e_dec(L, 2'd0));
    push(L, 4'hC, L, H, L, L, e_exec(4'h4, H, L, 2'd0));
    push(L, 4'hC, L, H, L, L, e_wb(L));
    // sw with halt requested from EXEC onward
    push(H, 4'hF, L, H, L, L, e_zero());
    push(L, 4'hF, L, H, L, L, e_fgo());
    push(L, 4'hF, L, H, L, L, e_dec(L, 2'd0));
    push(L, 4'hF, L, H, H, L, e_exec(4'hF, L, L, 2'd0));
    push(L, 4'hF, L, H, H, L, e_mem(H));
    push(L, 4'hF, L, H, H, L, e_halt());
    push(L, 4'hF, L, L, L, L, e_halt());
    push(L, 4'hF, L, L, L, L, e_fwait());
    // reset in the middle of a sw MEM wait
    push(H, 4'hF, L, L, L, L, e_zero());
    push(L, 4'hF, L, H, L, L, e_fgo());
    push(L, 4'hF, L, L, L, L, e_dec(L, 2'd0));
    push(L, 4'hF, L, L, L, L, e_exec(4'hF, L, L, 2'd0));
    push(L, 4'hF, L, L, L, L, e_mem(H));
    push(H, 4'hF, L, L, L, L, e_zero());
    push(L, 4'hF, L, L, L, L, e_fwait());
    // fast-branch build: branches resolve in DECODE, ALU ops unchanged
    push(H, 4'h8, H, H, L, H, e_zero());
    push(L, 4'h8, H, H, L, H, e_fgo());
    push(L, 4'h8, H, H, L, H, e_dec(H, 2'd2));
    push(L, 4'h8, H, L, L, H, e_fwait());
    push(H, 4'h8, L, H, L, H, e_zero());
    push(L, 4'h8, L, H, L, H, e_fgo());
    push(L, 4'h8, L, H, L, H, e_dec(L, 2'd2));
    push(L, 4'h8, L, L, L, H, e_fwait());
    push(H, 4'h7, L, H, L, H, e_zero());
    push(L, 4'h7, L, H, L, H, e_fgo());
    push(L, 4'h7, L, H, L, H, e_dec(H, 2'd1));
    push(H, 4'h4, L, H, L, H, e_zero());
    push(L, 4'h4, L, H, L, H, e_fgo());
    push(L, 4'h4, L, H, L, H, e_dec(L, 2'd0));
    push(L, 4'h4, L, H, L, H, e_exec(4'h4, L, L, 2'd0));
    push(L, 4'h4, L, H, L, H, e_wb(L));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].op, vecs[i].eq, vecs[i].mr, vecs[i].hr);
      chk(vecs[i].fb ? "vec_fb" : "vec", i, vecs[i].fb ? got_f : got_n, vecs[i].exp);
    end

    // Watchdog: four FETCH wait cycles then FAULT, sticky until reset
    drive(H, 4'h0, L, L, L);
    chk("wd_reset", 0, got_n, e_zero());
    for (int k = 0; k < 4; k++) begin
      drive(L, 4'h0, L, L, L);
      chk("wd_wait", k, got_n, e_fwait());
    end
    for (int k = 0; k < 12; k++) begin
      drive(L, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk("wd_fault", k, got_n, e_fault());
    end
    drive(H, 4'h0, L, H, L);
    chk("wd_clear", 0, got_n, e_zero());
    drive(L, 4'h0, L, L, L);
    chk("wd_restart", 0, got_n, e_fwait());

    // mem_ready on wait cycle 1..4 is always accepted
    for (int k = 1; k <= 4; k++) begin
      drive(H, 4'h4, L, L, L);
      for (int w = 1; w < k; w++) begin
        drive(L, 4'h4, L, L, L);
        chk("late_wait", k, got_n, e_fwait());
      end
      drive(L, 4'h4, L, H, L);
      chk("late_accept", k, got_n, e_fgo());
      drive(L, 4'h4, L, L, L);
      chk("late_decode", k, got_n, e_dec(L, 2'd0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
